// File: rtl/sram_arb_pkg.sv
// Shared types and default constants for the SRAM arbiter.
//   state_t : access sequencer states (IDLE, SETUP, ACCESS, DONE)
//   port_t  : index of a requester (0 = CPU, 1 = debug/program loader)
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  typedef logic port_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker.
//   Clk, Reset : clock, synchronous active-high reset
//   req[1:0]   : request from port 1 / port 0
//   update     : when high and a grant is produced, remember the winner
//   gnt[1:0]   : one-hot grant (combinational from req and last_gnt)
// On a tie the port that did not win last time is chosen. last_gnt resets
// to port 1, so port 0 wins the first tie after reset.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  port_t last_gnt;

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; without it synthesis would infer a latch.
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_gnt <= 1'b1;
    end else if (update && (gnt != 2'b00)) begin
      last_gnt <= gnt[1];
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous 16-bit SRAM between the CPU (port 0) and the
// debug/program loader (port 1). Each access runs SETUP -> ACCESS
// (WAIT_CYCLES strobe cycles) -> DONE -> IDLE; all outputs are registered.
//   Clk, Reset            : clock, synchronous active-high reset
//   req/we/be/addr/wdata  : per-port request, direction, byte enables,
//                           address and write data (sampled in IDLE only)
//   gnt0/1, done0/1       : ownership (SETUP..DONE), completion pulse
//   rdata                 : last read result, shared by both ports
//   CE/UB/LB/OE/WE, ADDR  : active-low SRAM controls and address
//   sram_dout/_en, sram_din : split data bus; the top level builds the
//                           tristate from sram_dout and sram_dout_en
// WAIT_CYCLES must lie in 1..15 (4-bit wait counter).
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int DATA_W      = SRAM_DATA_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [1:0]        be0,
  input  logic [1:0]        be1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_dout_en,
  input  logic [DATA_W-1:0] sram_din
);

  localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES - 1);

  state_t     state;
  logic [3:0] wait_cnt;
  port_t      cur_port;
  logic       cur_we;

  logic [1:0]        pick;
  logic              arb_update;
  port_t             sel_port;
  logic              sel_we;
  logic [1:0]        sel_be;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // The picker only remembers a winner when a grant is actually taken.
  assign arb_update = (state == IDLE);

  rr_arb2 u_rr_arb2 (
    .Clk    (Clk),
    .Reset  (Reset),
    .req    ({req1, req0}),
    .update (arb_update),
    .gnt    (pick)
  );

  // Request fields of whichever port the picker chose.
  always_comb begin
    sel_port  = pick[1];
    sel_we    = sel_port ? we1    : we0;
    sel_be    = sel_port ? be1    : be0;
    sel_addr  = sel_port ? addr1  : addr0;
    sel_wdata = sel_port ? wdata1 : wdata0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      cur_port     <= 1'b0;
      cur_we       <= 1'b0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      rdata        <= '0;
      CE           <= 1'b1;
      UB           <= 1'b1;
      LB           <= 1'b1;
      OE           <= 1'b1;
      WE           <= 1'b1;
      ADDR         <= '0;
      sram_dout    <= '0;
      sram_dout_en <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;

      unique case (state)
        IDLE: begin
          if (pick != 2'b00) begin
            state    <= SETUP;
            cur_port <= sel_port;
            cur_we   <= sel_we;
            gnt0     <= pick[0];
            gnt1     <= pick[1];
            CE       <= 1'b0;
            OE       <= 1'b1;
            WE       <= 1'b1;
            ADDR     <= sel_addr;
            if (sel_we) begin
              // be = 00 still strobes WE but keeps both byte lanes off.
              UB           <= ~sel_be[1];
              LB           <= ~sel_be[0];
              sram_dout    <= sel_wdata;
              sram_dout_en <= 1'b1;
            end else begin
              UB           <= 1'b0;
              LB           <= 1'b0;
              sram_dout_en <= 1'b0;
            end
          end
        end

        SETUP: begin
          state    <= ACCESS;
          wait_cnt <= 4'd0;
          if (cur_we) WE <= 1'b0;
          else        OE <= 1'b0;
        end

        ACCESS: begin
          if (wait_cnt == LAST_WAIT) begin
            state    <= DONE;
            wait_cnt <= 4'd0;
            OE       <= 1'b1;
            WE       <= 1'b1;
            if (!cur_we) rdata <= sram_din;
            done0    <= ~cur_port;
            done1    <= cur_port;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end

        DONE: begin
          // CE, ADDR and the data driver stayed on through DONE for write
          // hold time; release them now.
          state        <= IDLE;
          gnt0         <= 1'b0;
          gnt1         <= 1'b0;
          CE           <= 1'b1;
          UB           <= 1'b1;
          LB           <= 1'b1;
          sram_dout_en <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: a table of single accesses with a
// behavioural SRAM model, a done/rdata scoreboard, hand-written sequences
// for ties, mid-access arrival and reset abort, plus WAIT_CYCLES=1 and 15
// instances for strobe-width and latency boundaries.
module tb_sram_arbiter;

  localparam int W = 2;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset;
  logic        req0, req1, we0, we1;
  logic [1:0]  be0, be1;
  logic [19:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1;
  logic [15:0] rdata;
  logic        CE, UB, LB, OE, WE;
  logic [19:0] ADDR;
  logic [15:0] sram_dout;
  logic        sram_dout_en;
  logic [15:0] sram_din = '0;

  sram_arbiter #(.WAIT_CYCLES(W)) u_dut (
    .Clk(Clk), .Reset(Reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .be0(be0), .be1(be1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata),
    .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .ADDR(ADDR),
    .sram_dout(sram_dout), .sram_dout_en(sram_dout_en), .sram_din(sram_din)
  );

  // Boundary builds: WAIT_CYCLES = 1 (suffix _a) and 15 (suffix _b), port 0 reads only.
  logic        rq_a, rq_b;
  logic        gnt0_a, gnt1_a, done0_a, done1_a, CE_a, UB_a, LB_a, OE_a, WE_a, en_a;
  logic        gnt0_b, gnt1_b, done0_b, done1_b, CE_b, UB_b, LB_b, OE_b, WE_b, en_b;
  logic [15:0] rdata_a, rdata_b, dout_a, dout_b;
  logic [19:0] ADDR_a, ADDR_b;
  logic [15:0] din_a = '0;
  logic [15:0] din_b = '0;

  sram_arbiter #(.WAIT_CYCLES(1)) u_w1 (
    .Clk(Clk), .Reset(Reset),
    .req0(rq_a), .req1(1'b0), .we0(1'b0), .we1(1'b0), .be0(2'b11), .be1(2'b11),
    .addr0(20'h00012), .addr1(20'h0), .wdata0(16'h0), .wdata1(16'h0),
    .gnt0(gnt0_a), .gnt1(gnt1_a), .done0(done0_a), .done1(done1_a), .rdata(rdata_a),
    .CE(CE_a), .UB(UB_a), .LB(LB_a), .OE(OE_a), .WE(WE_a), .ADDR(ADDR_a),
    .sram_dout(dout_a), .sram_dout_en(en_a), .sram_din(din_a)
  );

  sram_arbiter #(.WAIT_CYCLES(15)) u_w15 (
    .Clk(Clk), .Reset(Reset),
    .req0(rq_b), .req1(1'b0), .we0(1'b0), .we1(1'b0), .be0(2'b11), .be1(2'b11),
    .addr0(20'h00012), .addr1(20'h0), .wdata0(16'h0), .wdata1(16'h0),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .done0(done0_b), .done1(done1_b), .rdata(rdata_b),
    .CE(CE_b), .UB(UB_b), .LB(LB_b), .OE(OE_b), .WE(WE_b), .ADDR(ADDR_b),
    .sram_dout(dout_b), .sram_dout_en(en_b), .sram_din(din_b)
  );

  // ---------------- counters and check ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- SRAM model ----------------
  logic [15:0] mem [logic [19:0]];
  logic [15:0] wr_v;

  function automatic logic [15:0] mem_rd(input logic [19:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  // Sampled mid-cycle, away from the DUT's active edge.
  always @(negedge Clk) begin
    if (!CE && !WE && sram_dout_en) begin
      wr_v = mem_rd(ADDR);
      if (!UB) wr_v[15:8] = sram_dout[15:8];
      if (!LB) wr_v[7:0]  = sram_dout[7:0];
      mem[ADDR] = wr_v;
    end
    sram_din = (!CE && !OE) ? mem_rd(ADDR) : 16'h0000;
    din_a    = (!CE_a && !OE_a) ? 16'hC0DE : 16'h0000;
    din_b    = (!CE_b && !OE_b) ? 16'h5EED : 16'h0000;
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        port;
    logic [15:0] rdata;
  } sb_t;

  sb_t sb[$];
  sb_t sb_e;

  always @(negedge Clk) begin
    if (!Reset && (done0 || done1)) begin
      check("done_onehot", 32'(done0 & done1), 32'd0);
      if (sb.size() == 0) begin
        check("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        sb_e = sb.pop_front();
        check("sb_done_port", 32'(done1), 32'(sb_e.port));
        check("sb_rdata", 32'(rdata), 32'(sb_e.rdata));
      end
    end
  end

  // ---------------- single access driver ----------------
  typedef struct packed {
    logic        port;
    logic        we;
    logic [1:0]  be;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  // Called from a negedge in DONE or IDLE; returns at the negedge inside DONE.
  task automatic run_access(input vec_t v);
    int   n;
    int   oe_n;
    int   we_n;
    logic en_ok;
    logic strobe_ok;
    logic seen;
    @(negedge Clk);
    if (v.port == 1'b0) begin
      req0 = 1'b1; we0 = v.we; be0 = v.be; addr0 = v.addr; wdata0 = v.wdata;
    end else begin
      req1 = 1'b1; we1 = v.we; be1 = v.be; addr1 = v.addr; wdata1 = v.wdata;
    end
    sb.push_back('{port: v.port, rdata: v.exp_rdata});
    @(posedge Clk);
    @(negedge Clk);
    req0 = 1'b0;
    req1 = 1'b0;
    check("acc_gnt", 32'({gnt1, gnt0}), v.port ? 32'd2 : 32'd1);
    check("acc_addr", 32'(ADDR), 32'(v.addr));
    n = 1; oe_n = 0; we_n = 0; en_ok = 1'b1; strobe_ok = 1'b1; seen = 1'b0;
    while (n < 40) begin
      if (!OE) oe_n++;
      if (!WE) we_n++;
      if (sram_dout_en !== v.we) en_ok = 1'b0;
      if (!OE || !WE) begin
        if (CE !== 1'b0) strobe_ok = 1'b0;
        if ({UB, LB} !== (v.we ? ~v.be : 2'b00)) strobe_ok = 1'b0;
        if (v.we && (sram_dout !== v.wdata)) strobe_ok = 1'b0;
      end
      if (done0 || done1) begin
        seen = 1'b1;
        break;
      end
      @(negedge Clk);
      n++;
    end
    check("acc_done_seen", 32'(seen), 32'd1);
    check("acc_latency", 32'(n), 32'(W + 2));
    check("acc_strobe_width", 32'(v.we ? we_n : oe_n), 32'(W));
    check("acc_other_strobe", 32'(v.we ? oe_n : we_n), 32'd0);
    check("acc_dout_en", 32'(en_ok), 32'd1);
    check("acc_strobe_ctl", 32'(strobe_ok), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  vec_t        vecs [9];
  int          n;
  int          n_done;
  int          n_gnt;
  logic [1:0]  prev_g;
  logic        both_gnt;
  logic        order [4];
  int          lat_a, lat_b, oe_a, oe_b;
  logic [15:0] rd_a, rd_b;

  initial begin
    //             port  we    be     addr        wdata     exp rdata
    vecs[0] = '{1'b0, 1'b0, 2'b11, 20'h00012, 16'h0000, 16'hBEEF};
    vecs[1] = '{1'b1, 1'b1, 2'b01, 20'h00300, 16'h1234, 16'hBEEF};
    vecs[2] = '{1'b0, 1'b0, 2'b11, 20'h00300, 16'h0000, 16'h0034};
    vecs[3] = '{1'b1, 1'b1, 2'b10, 20'h00300, 16'hABCD, 16'h0034};
    vecs[4] = '{1'b1, 1'b0, 2'b11, 20'h00300, 16'h0000, 16'hAB34};
    vecs[5] = '{1'b0, 1'b1, 2'b00, 20'h00050, 16'hFFFF, 16'hAB34};
    vecs[6] = '{1'b1, 1'b0, 2'b11, 20'h00050, 16'h0000, 16'h0F0F};
    vecs[7] = '{1'b0, 1'b1, 2'b11, 20'h00050, 16'h5A5A, 16'h0F0F};
    vecs[8] = '{1'b0, 1'b0, 2'b11, 20'h00050, 16'h0000, 16'h5A5A};

    mem[20'h00012] = 16'hBEEF;
    mem[20'h00050] = 16'h0F0F;

    Reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    be0 = 2'b11; be1 = 2'b11; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    rq_a = 1'b0; rq_b = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);

    // Reset values
    check("rst_ctl", 32'({CE, UB, LB, OE, WE}), 32'h1F);
    check("rst_addr", 32'(ADDR), 32'd0);
    check("rst_dout", 32'(sram_dout), 32'd0);
    check("rst_dout_en", 32'(sram_dout_en), 32'd0);
    check("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
    check("rst_done", 32'({done1, done0}), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    Reset = 1'b0;

    // Table of single accesses
    for (int i = 0; i < 9; i++) run_access(vecs[i]);
    check("mem_0300", 32'(mem_rd(20'h00300)), 32'h0000AB34);
    check("mem_0050", 32'(mem_rd(20'h00050)), 32'h00005A5A);

    // Both ports held high from reset: grants alternate 0,1,0,1
    @(negedge Clk);
    Reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 20'h00012; addr1 = 20'h00050;
    sb.push_back('{port: 1'b0, rdata: 16'hBEEF});
    sb.push_back('{port: 1'b1, rdata: 16'h5A5A});
    sb.push_back('{port: 1'b0, rdata: 16'hBEEF});
    sb.push_back('{port: 1'b1, rdata: 16'h5A5A});
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    n = 0; n_done = 0; n_gnt = 0; prev_g = 2'b00; both_gnt = 1'b0;
    while (n < 100 && n_done < 4) begin
      @(negedge Clk);
      n++;
      if (gnt0 && gnt1) both_gnt = 1'b1;
      if (({gnt1, gnt0} != 2'b00) && (prev_g == 2'b00) && (n_gnt < 4)) begin
        order[n_gnt] = gnt1;
        n_gnt++;
      end
      prev_g = {gnt1, gnt0};
      if (done0 || done1) n_done++;
    end
    req0 = 1'b0; req1 = 1'b0;
    check("tie_dones", 32'(n_done), 32'd4);
    check("tie_grants", 32'(n_gnt), 32'd4);
    check("tie_never_both", 32'(both_gnt), 32'd0);
    check("tie_order", 32'({order[0], order[1], order[2], order[3]}), 32'b0101);

    // Port 1 arrives while port 0 is in ACCESS; its fields change in IDLE
    @(negedge Clk);
    req0 = 1'b1; we0 = 1'b0; be0 = 2'b11; addr0 = 20'h00012;
    sb.push_back('{port: 1'b0, rdata: 16'hBEEF});
    @(posedge Clk);
    @(negedge Clk);                     // SETUP of port 0
    req0 = 1'b0;
    @(negedge Clk);                     // ACCESS of port 0
    req1 = 1'b1; we1 = 1'b1; be1 = 2'b11; addr1 = 20'h00AAA; wdata1 = 16'h1111;
    sb.push_back('{port: 1'b1, rdata: 16'hBEEF});
    n = 0;
    while (!done0 && n < 20) begin @(negedge Clk); n++; end
    check("mid_done0_seen", 32'(done0), 32'd1);
    @(negedge Clk);                     // IDLE: present the final fields
    check("mid_idle_gnt", 32'({gnt1, gnt0}), 32'd0);
    addr1 = 20'h00077; wdata1 = 16'h7777;
    @(negedge Clk);                     // SETUP of port 1
    req1 = 1'b0;
    check("mid_gnt1", 32'({gnt1, gnt0}), 32'd2);
    check("mid_addr", 32'(ADDR), 32'h00077);
    check("mid_wdata", 32'(sram_dout), 32'h7777);
    n = 0;
    while (!done1 && n < 20) begin @(negedge Clk); n++; end
    check("mid_done1_seen", 32'(done1), 32'd1);
    run_access('{1'b0, 1'b0, 2'b11, 20'h00077, 16'h0000, 16'h7777});
    check("mid_stale_not_written", 32'(mem_rd(20'h00AAA)), 32'd0);

    // Reset during ACCESS of a port-0 write, then a tie
    @(negedge Clk);
    req0 = 1'b1; we0 = 1'b1; be0 = 2'b11; addr0 = 20'h00999; wdata0 = 16'hDEAD;
    @(posedge Clk);
    @(negedge Clk);                     // SETUP
    req0 = 1'b0;
    @(negedge Clk);                     // ACCESS
    check("rst_pre_we", 32'(WE), 32'd0);
    Reset = 1'b1;
    @(negedge Clk);
    check("rst_mid_we_ce", 32'({WE, CE}), 32'd3);
    check("rst_mid_dout_en", 32'(sram_dout_en), 32'd0);
    check("rst_mid_gnt0", 32'(gnt0), 32'd0);
    check("rst_mid_done0", 32'(done0), 32'd0);
    sb.delete();
    Reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 20'h00012; addr1 = 20'h00050;
    sb.push_back('{port: 1'b0, rdata: 16'hBEEF});
    @(posedge Clk);
    @(negedge Clk);
    req0 = 1'b0; req1 = 1'b0;
    check("rst_tie_gnt", 32'({gnt1, gnt0}), 32'd1);
    n = 0;
    while (!(done0 || done1) && n < 20) begin @(negedge Clk); n++; end
    check("rst_tie_done_seen", 32'(done0), 32'd1);

    // WAIT_CYCLES = 1 and 15 builds
    @(negedge Clk);
    rq_a = 1'b1; rq_b = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    rq_a = 1'b0; rq_b = 1'b0;
    n = 1; lat_a = 0; lat_b = 0; oe_a = 0; oe_b = 0; rd_a = '0; rd_b = '0;
    while (n <= 40 && (lat_a == 0 || lat_b == 0)) begin
      if (!OE_a) oe_a++;
      if (!OE_b) oe_b++;
      if (done0_a && lat_a == 0) begin lat_a = n; rd_a = rdata_a; end
      if (done0_b && lat_b == 0) begin lat_b = n; rd_b = rdata_b; end
      @(negedge Clk);
      n++;
    end
    check("w1_latency", 32'(lat_a), 32'd3);
    check("w15_latency", 32'(lat_b), 32'd17);
    check("w1_oe_width", 32'(oe_a), 32'd1);
    check("w15_oe_width", 32'(oe_b), 32'd15);
    check("w1_rdata", 32'(rd_a), 32'hC0DE);
    check("w15_rdata", 32'(rd_b), 32'h5EED);

    repeat (4) @(negedge Clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its end, %0d compared so far", n_cmp);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single off-chip 16-bit SRAM (active-low CE/UB/LB/OE/WE, 20-bit ADDR) between two requesters: port 0 is the CPU memory interface, port 1 is the debug/program loader.
- Sequences each access through setup / strobe / recover phases, with a parameterised strobe width.
- Returns per-port completion pulses and registered read data.
- Sits between the CPU/loader and the memory I/O bridge. It contains no tristates: the top level builds the bidirectional Data bus from sram_dout and sram_dout_en.

Parameters:
- WAIT_CYCLES, 2, number of cycles the OE/WE strobe is held; legal range 1..15.
- ADDR_W, 20, SRAM address width.
- DATA_W, 16, SRAM data width.

Ports:
- Clk  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- req0, req1  in  1  access request from port 0 / port 1.
- we0, we1  in  1  1 = write, 0 = read.
- be0, be1  in  2  byte enables for writes: bit1 = upper byte, bit0 = lower byte.
- addr0, addr1  in  ADDR_W  access address.
- wdata0, wdata1  in  DATA_W  write data.
- gnt0, gnt1  out  1  port owns the SRAM (high from SETUP through DONE).
- done0, done1  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  registered read data, shared by both ports.
- CE, UB, LB, OE, WE  out  1 each  SRAM controls, active-low.
- ADDR  out  ADDR_W  SRAM address.
- sram_dout  out  DATA_W  write data toward the SRAM.
- sram_dout_en  out  1  top level drives the Data bus when this is 1.
- sram_din  in  DATA_W  Data bus as read back from the SRAM.

Behaviour:
- Reset values: CE, UB, LB, OE and WE = 1; ADDR = 0; sram_dout = 0; sram_dout_en = 0; gnt0/1 = 0; done0/1 = 0; rdata = 0; state = IDLE; wait counter = 0; last_gnt = 1.
- All outputs are registered.
- A reset asserted mid-access returns the block to the reset values at the next edge. No done pulse is issued and the access is abandoned.
- IDLE: all controls are deasserted. At the clock edge, if any req is high:
  - Grant one port and latch that port's we, be, addr and wdata.
  - Set that port's gnt and move to SETUP.
  - Requests are sampled only in IDLE, so inputs only need to be stable in that cycle.
- Arbitration is round-robin:
  - Only one port requesting: it wins.
  - Both ports requesting: the port not equal to last_gnt wins; last_gnt is updated on every grant.
  - After reset, port 0 wins the first tie.
- SETUP (1 cycle):
  - CE = 0, ADDR valid.
  - Reads: UB = LB = 0.
  - Writes: UB = ~be[1], LB = ~be[0]; sram_dout_en = 1.
  - OE = WE = 1.
- ACCESS (WAIT_CYCLES cycles, counted by the wait counter):
  - SETUP signals are held.
  - Reads: OE = 0.
  - Writes: WE = 0.
  - On the edge ending the last ACCESS cycle, a read captures sram_din into rdata.
- DONE (1 cycle):
  - OE = WE = 1; CE, ADDR and sram_dout_en are held to give write data hold time.
  - done of the granted port = 1.
  - Next state is always IDLE; on entering IDLE, gnt, CE, UB, LB and sram_dout_en are deasserted.
- Latency: a request sampled at IDLE edge t produces done at cycle t + 2 + WAIT_CYCLES. The minimum period between grants is WAIT_CYCLES + 3 cycles.
- Requester rule:
  - On seeing done, the requester deasserts req, or presents a new request, by the following edge.
  - A req still high in IDLE is treated as a new access.
- rdata holds its value until the next read completes; writes leave it unchanged.
- be = 00 on a write performs a cycle with WE strobed but UB = LB = 1, so no byte is written. done is still issued.
- A request arriving while another port holds the grant waits, unchanged, until IDLE; it is never dropped.
- Counter width is 4 bits; WAIT_CYCLES = 1 gives exactly one ACCESS cycle, with no wrap and no zero case.

Decomposition:
- Package sram_arb_pkg holds:
  - the state typedef: IDLE, SETUP, ACCESS, DONE;
  - ADDR_W/DATA_W default constants;
  - a port-index typedef.
- Sub-module rr_arb2: a two-input round-robin picker with a last_gnt register and update enable, producing a one-hot grant. The main block holds the FSM, latches and output registers.

Test Plan:
- Port 0 only: single read, addr=0x00012, sram_din model returns 0xBEEF, WAIT_CYCLES=2 → OE low for exactly 2 cycles; done0 four cycles after the sampling edge; rdata=0xBEEF; done1 stays 0.
- Port 1 only: write, addr=0x00300, wdata=0x1234, be=01 → LB=0, UB=1, WE low 2 cycles; sram_dout_en high from SETUP through DONE; sram_dout=0x1234; rdata unchanged.
- req0 and req1 both held high from reset → grants alternate 0,1,0,1 across 4 accesses; done pulses alternate; never two gnt high together.
- Port 1 requests while port 0 is in ACCESS → port 1 is granted in the first IDLE after done0; its latched addr/wdata are the values present at that IDLE edge.
- Reset asserted during ACCESS of a write → next cycle: WE=CE=1, sram_dout_en=0, gnt0=done0=0; a subsequent tie is won by port 0.
- WAIT_CYCLES=1 and WAIT_CYCLES=15 builds: a read completes in 3 and 17 cycles respectively; OE low width equals WAIT_CYCLES.
